// File: rtl/corePckg.sv
// Shared decode-stage types, opcode constants and the instruction decoder helper.
package corePckg;

  localparam int cXLEN       = 32;
  localparam int cRegSelBitW = 5;

  typedef enum logic [3:0] {
    LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, ILLEGAL
  } tOpClass;

  localparam logic [6:0] cOpcLui    = 7'b0110111;
  localparam logic [6:0] cOpcAuipc  = 7'b0010111;
  localparam logic [6:0] cOpcJal    = 7'b1101111;
  localparam logic [6:0] cOpcJalr   = 7'b1100111;
  localparam logic [6:0] cOpcBranch = 7'b1100011;
  localparam logic [6:0] cOpcLoad   = 7'b0000011;
  localparam logic [6:0] cOpcStore  = 7'b0100011;
  localparam logic [6:0] cOpcOpImm  = 7'b0010011;
  localparam logic [6:0] cOpcOp     = 7'b0110011;

  typedef struct packed {
    logic                   dv;
    logic [cRegSelBitW-1:0] addr;
    logic [cXLEN-1:0]       data;
  } tRegOp;

  typedef struct packed {
    logic                   valid;
    logic [cXLEN-1:0]       pc;
    tOpClass                opClass;
    logic [2:0]             funct3;
    logic                   funct7b5;
    logic [cRegSelBitW-1:0] rdAddr;
    logic [cRegSelBitW-1:0] rs1Addr;
    logic [cRegSelBitW-1:0] rs2Addr;
    logic [cXLEN-1:0]       rs1Data;
    logic [cXLEN-1:0]       rs2Data;
    logic [cXLEN-1:0]       imm;
    logic                   illegal;
  } tDecOp;

  // Register address fields are zeroed when the class does not use them, so a
  // zero address doubles as "not used" for hazard checks.
  function automatic tDecOp decode_instr(input logic [cXLEN-1:0] instr);
    tDecOp d;
    logic  use_rd;
    logic  use_rs1;
    logic  use_rs2;
    d       = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (instr != '0) begin
      d.valid    = 1'b1;
      d.funct3   = instr[14:12];
      d.funct7b5 = instr[30];
      case (instr[6:0])
        cOpcLui: begin
          d.opClass = LUI;
          use_rd    = 1'b1;
          d.imm     = {instr[31:12], 12'b0};
        end
        cOpcAuipc: begin
          d.opClass = AUIPC;
          use_rd    = 1'b1;
          d.imm     = {instr[31:12], 12'b0};
        end
        cOpcJal: begin
          d.opClass = JAL;
          use_rd    = 1'b1;
          d.imm     = {{(cXLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        cOpcJalr: begin
          d.opClass = JALR;
          use_rd    = 1'b1;
          use_rs1   = 1'b1;
          d.imm     = {{(cXLEN-12){instr[31]}}, instr[31:20]};
        end
        cOpcBranch: begin
          d.opClass = BRANCH;
          use_rs1   = 1'b1;
          use_rs2   = 1'b1;
          d.imm     = {{(cXLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        cOpcLoad: begin
          d.opClass = LOAD;
          use_rd    = 1'b1;
          use_rs1   = 1'b1;
          d.imm     = {{(cXLEN-12){instr[31]}}, instr[31:20]};
        end
        cOpcStore: begin
          d.opClass = STORE;
          use_rs1   = 1'b1;
          use_rs2   = 1'b1;
          d.imm     = {{(cXLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
        end
        cOpcOpImm: begin
          d.opClass = OPIMM;
          use_rd    = 1'b1;
          use_rs1   = 1'b1;
          d.imm     = {{(cXLEN-12){instr[31]}}, instr[31:20]};
        end
        cOpcOp: begin
          d.opClass = OP;
          use_rd    = 1'b1;
          use_rs1   = 1'b1;
          use_rs2   = 1'b1;
        end
        default: begin
          d.opClass = ILLEGAL;
          d.illegal = 1'b1;
        end
      endcase
      d.rdAddr  = use_rd  ? instr[11:7]  : '0;
      d.rs1Addr = use_rs1 ? instr[19:15] : '0;
      d.rs2Addr = use_rs2 ? instr[24:20] : '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 31-entry register file, two async read ports and one write port; x0 reads 0.
// DECODE_RF_BYPASS_EN makes reads write-first against the same-cycle write.
module reg_file
  import corePckg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [cRegSelBitW-1:0] wr_addr,
  input  logic [cXLEN-1:0]       wr_data,
  input  logic [cRegSelBitW-1:0] rd_addr1,
  output logic [cXLEN-1:0]       rd_data1,
  input  logic [cRegSelBitW-1:0] rd_addr2,
  output logic [cXLEN-1:0]       rd_data2
);

  logic [cXLEN-1:0] regs [1:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data1 = '0;
    rd_data2 = '0;
    if (rd_addr1 != '0) rd_data1 = regs[rd_addr1];
    if (rd_addr2 != '0) rd_data2 = regs[rd_addr2];
`ifdef DECODE_RF_BYPASS_EN
    if (wr_en && rd_addr1 != '0 && rd_addr1 == wr_addr) rd_data1 = wr_data;
    if (wr_en && rd_addr2 != '0 && rd_addr2 == wr_addr) rd_data2 = wr_data;
`else
    rd_data1 = rd_data1;
    rd_data2 = rd_data2;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register file, decode, startup/flush bubbles, stall hold and load-use hold.
// DECODE_RF_BYPASS_EN selects write-first register reads instead of a writeback hazard hold.
module decode_stage
  import corePckg::*;
#(
  parameter int cStartupCycles = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [cXLEN-1:0] iInstr,
  input  logic [cXLEN-1:0] iCurPc,
  input  tRegOp            iRegOp,
  input  logic             iStall,
  input  logic             iFlush,
  output tDecOp            oDecOp,
  output logic             oLoadUse
);

  typedef enum logic [1:0] {sInit, sRun, sFlush} tState;

  localparam int cCntW = (cStartupCycles > 1) ? $clog2(cStartupCycles) : 1;

  tState            state, state_next;
  logic [cCntW-1:0] cnt, cnt_next;
  tDecOp            cur, fresh, held, dec_next;
  logic [cXLEN-1:0] rs1_data, rs2_data;
  logic             load_hazard, wb_hazard;

  assign cur = decode_instr(iInstr);

  reg_file u_reg_file (
    .clk      (iClk),
    .rst_n    (iRst),
    .wr_en    (iRegOp.dv),
    .wr_addr  (iRegOp.addr),
    .wr_data  (iRegOp.data),
    .rd_addr1 (cur.rs1Addr),
    .rd_data1 (rs1_data),
    .rd_addr2 (cur.rs2Addr),
    .rd_data2 (rs2_data)
  );

  always_comb begin
    fresh = cur;
    held  = oDecOp;
    if (cur.valid) begin
      fresh.pc      = iCurPc;
      fresh.rs1Data = rs1_data;
      fresh.rs2Data = rs2_data;
    end
    // A held op must not go stale while the stall lets a writeback land.
    if (iRegOp.dv && iRegOp.addr != '0) begin
      if (iRegOp.addr == oDecOp.rs1Addr) held.rs1Data = iRegOp.data;
      if (iRegOp.addr == oDecOp.rs2Addr) held.rs2Data = iRegOp.data;
    end
  end

  always_comb begin
    load_hazard = oDecOp.valid && oDecOp.opClass == LOAD && oDecOp.rdAddr != '0 &&
                  (cur.rs1Addr == oDecOp.rdAddr || cur.rs2Addr == oDecOp.rdAddr);
`ifdef DECODE_RF_BYPASS_EN
    wb_hazard = 1'b0;
`else
    wb_hazard = iRegOp.dv && iRegOp.addr != '0 &&
                (cur.rs1Addr == iRegOp.addr || cur.rs2Addr == iRegOp.addr);
`endif
  end

  assign oLoadUse = load_hazard || wb_hazard;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dec_next   = oDecOp;
    case (state)
      sInit: begin
        dec_next = '0;
        cnt_next = cnt + 1'b1;
        if (cnt == cCntW'(cStartupCycles - 1)) state_next = sRun;
      end
      sRun: begin
        if (iFlush) begin
          dec_next   = '0;
          state_next = sFlush;
        end else if (iStall) begin
          dec_next = held;
        end else if (oLoadUse) begin
          dec_next = '0;
        end else begin
          dec_next = fresh;
        end
      end
      sFlush: begin
        dec_next = '0;
        if (!iFlush) state_next = sRun;
      end
      default: begin
        dec_next   = '0;
        state_next = sInit;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state  <= sInit;
      cnt    <= '0;
      oDecOp <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      oDecOp <= dec_next;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus random traffic against a behavioural model.
// Expectations follow DECODE_RF_BYPASS_EN when it is defined for the build.
module tb_decode_stage;
  import corePckg::*;

  logic        iClk = 1'b0;
  logic        iRst = 1'b0;
  logic [31:0] iInstr = '0;
  logic [31:0] iCurPc = '0;
  tRegOp       reg_op = '0;
  logic        iStall = 1'b0;
  logic        iFlush = 1'b0;
  tDecOp       oDecOp;
  logic        oLoadUse;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [0:31];

  decode_stage #(.cStartupCycles(2)) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iInstr   (iInstr),
    .iCurPc   (iCurPc),
    .iRegOp   (reg_op),
    .iStall   (iStall),
    .iFlush   (iFlush),
    .oDecOp   (oDecOp),
    .oLoadUse (oLoadUse)
  );

  always #5 iClk = ~iClk;

  function automatic logic [31:0] sra(input logic [31:0] v, input int n);
    return $signed(v) >>> n;
  endfunction

  // Reference decode built from the ISA field layout with shifts and masks.
  function automatic tDecOp m_decode(input logic [31:0] instr);
    tDecOp d;
    bit    r1, r2, wd;
    d  = '0;
    r1 = 0; r2 = 0; wd = 0;
    if (instr == 32'h0) return d;
    d.valid    = 1'b1;
    d.funct3   = instr[14:12];
    d.funct7b5 = instr[30];
    case (instr[6:0])
      7'h37: begin d.opClass = LUI;    wd = 1; d.imm = instr & 32'hFFFFF000; end
      7'h17: begin d.opClass = AUIPC;  wd = 1; d.imm = instr & 32'hFFFFF000; end
      7'h6F: begin
        d.opClass = JAL; wd = 1;
        d.imm = (sra(instr, 11) & 32'hFFF00000) | (instr & 32'h000FF000) |
                (32'(instr[20]) << 11) | (32'(instr[30:21]) << 1);
      end
      7'h67: begin d.opClass = JALR;   wd = 1; r1 = 1; d.imm = sra(instr, 20); end
      7'h63: begin
        d.opClass = BRANCH; r1 = 1; r2 = 1;
        d.imm = (sra(instr, 19) & 32'hFFFFF000) | (32'(instr[7]) << 11) |
                (32'(instr[30:25]) << 5) | (32'(instr[11:8]) << 1);
      end
      7'h03: begin d.opClass = LOAD;   wd = 1; r1 = 1; d.imm = sra(instr, 20); end
      7'h23: begin
        d.opClass = STORE; r1 = 1; r2 = 1;
        d.imm = (sra(instr, 20) & 32'hFFFFFFE0) | 32'(instr[11:7]);
      end
      7'h13: begin d.opClass = OPIMM;  wd = 1; r1 = 1; d.imm = sra(instr, 20); end
      7'h33: begin d.opClass = OP;     wd = 1; r1 = 1; r2 = 1; end
      default: begin d.opClass = ILLEGAL; d.illegal = 1'b1; end
    endcase
    if (wd) d.rdAddr  = instr[11:7];
    if (r1) d.rs1Addr = instr[19:15];
    if (r2) d.rs2Addr = instr[24:20];
    return d;
  endfunction

  function automatic bit m_load_use(input tDecOp out, input logic [31:0] instr, input tRegOp w);
    tDecOp d;
    bit    hz;
    d  = m_decode(instr);
    hz = out.valid && out.opClass == LOAD && out.rdAddr != 0 &&
         (d.rs1Addr == out.rdAddr || d.rs2Addr == out.rdAddr);
`ifndef DECODE_RF_BYPASS_EN
    hz = hz || (w.dv && w.addr != 0 && (d.rs1Addr == w.addr || d.rs2Addr == w.addr));
`endif
    return hz;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input tRegOp w);
    if (a == 0) return 32'h0;
`ifdef DECODE_RF_BYPASS_EN
    if (w.dv && w.addr == a) return w.data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r        = $urandom;
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 11))
      0:  r[6:0] = 7'h37;
      1:  r[6:0] = 7'h17;
      2:  r[6:0] = 7'h6F;
      3:  r[6:0] = 7'h67;
      4:  r[6:0] = 7'h63;
      5:  r[6:0] = 7'h03;
      6:  r[6:0] = 7'h23;
      7:  r[6:0] = 7'h13;
      8:  r[6:0] = 7'h33;
      9:  r = 32'h0;
      10: r[6:0] = 7'h7F;
      default: r[6:0] = 7'h03;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    iRst = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    checks++;
    if (oDecOp !== '0 || oLoadUse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: decop=%h loaduse=%b expected 0/0", oDecOp, oLoadUse);
    end
  endtask

  task automatic test_startup();
    iRst   = 1'b1;
    iInstr = 32'h00500093;
    iCurPc = 32'h100;
    for (int n = 0; n < 2; n++) begin
      @(posedge iClk); #1;
      checks++;
      if (oDecOp.valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL startup_bubble%0d: valid=%b expected 0", n, oDecOp.valid);
      end
    end
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b1 || oDecOp.opClass !== OPIMM || oDecOp.rdAddr !== 5'd1 ||
        oDecOp.imm !== 32'd5 || oDecOp.pc !== 32'h100 || oDecOp.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL startup_first_op: valid=%b class=%0d rd=%0d imm=%h pc=%h expected 1/OPIMM/1/5/100",
               oDecOp.valid, oDecOp.opClass, oDecOp.rdAddr, oDecOp.imm, oDecOp.pc);
    end
  endtask

  task automatic test_bypass();
    @(negedge iClk);
    iInstr = 32'h00018133;
    iCurPc = 32'h104;
    reg_op.dv = 1'b1; reg_op.addr = 5'd3; reg_op.data = 32'hDEADBEEF;
    #1;
`ifdef DECODE_RF_BYPASS_EN
    checks++;
    if (oLoadUse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bypass_no_hold: loaduse=%b expected 0", oLoadUse);
    end
    @(posedge iClk); #1;
`else
    checks++;
    if (oLoadUse !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wb_hazard_hold: loaduse=%b expected 1", oLoadUse);
    end
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wb_hazard_bubble: valid=%b expected 0", oDecOp.valid);
    end
    @(negedge iClk);
    reg_op.dv = 1'b0;
    @(posedge iClk); #1;
`endif
    checks++;
    if (oDecOp.valid !== 1'b1 || oDecOp.rs1Addr !== 5'd3 || oDecOp.rs1Data !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL rf_write_read: valid=%b rs1=%0d rs1Data=%h expected 1/3/deadbeef",
               oDecOp.valid, oDecOp.rs1Addr, oDecOp.rs1Data);
    end
    @(negedge iClk);
    reg_op.dv = 1'b0;
  endtask

  task automatic test_stall_refresh();
    iStall = 1'b1;
    reg_op.dv = 1'b1; reg_op.addr = 5'd3; reg_op.data = 32'h11112222;
    iInstr = 32'h00500093;
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b1 || oDecOp.opClass !== OP || oDecOp.pc !== 32'h104 ||
        oDecOp.rs1Data !== 32'h11112222) begin
      errors++;
      $display("[TB] FAIL stall_refresh: valid=%b class=%0d pc=%h rs1Data=%h expected 1/OP/104/11112222",
               oDecOp.valid, oDecOp.opClass, oDecOp.pc, oDecOp.rs1Data);
    end
    @(negedge iClk);
    iStall = 1'b0;
    reg_op.dv = 1'b0;
  endtask

  task automatic test_load_use();
    iInstr = 32'h0000A103;
    iCurPc = 32'h200;
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b1 || oDecOp.opClass !== LOAD || oDecOp.rdAddr !== 5'd2 ||
        oDecOp.funct3 !== 3'd2) begin
      errors++;
      $display("[TB] FAIL load_issue: valid=%b class=%0d rd=%0d f3=%0d expected 1/LOAD/2/2",
               oDecOp.valid, oDecOp.opClass, oDecOp.rdAddr, oDecOp.funct3);
    end
    @(negedge iClk);
    iInstr = 32'h00210233;
    iCurPc = 32'h204;
    #1;
    checks++;
    if (oLoadUse !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_use_flag: loaduse=%b expected 1", oLoadUse);
    end
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b0 || oLoadUse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_use_bubble: valid=%b loaduse=%b expected 0/0", oDecOp.valid, oLoadUse);
    end
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b1 || oDecOp.opClass !== OP || oDecOp.rdAddr !== 5'd4 ||
        oDecOp.rs1Addr !== 5'd2 || oDecOp.rs2Addr !== 5'd2 || oDecOp.pc !== 32'h204) begin
      errors++;
      $display("[TB] FAIL load_use_reissue: valid=%b class=%0d rd=%0d rs1=%0d rs2=%0d pc=%h",
               oDecOp.valid, oDecOp.opClass, oDecOp.rdAddr, oDecOp.rs1Addr, oDecOp.rs2Addr, oDecOp.pc);
    end
  endtask

  task automatic test_flush_stall();
    @(negedge iClk);
    iInstr = 32'h00500093;
    iCurPc = 32'h300;
    iFlush = 1'b1;
    iStall = 1'b1;
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_bubble1: valid=%b expected 0", oDecOp.valid);
    end
    @(negedge iClk);
    iFlush = 1'b0;
    iStall = 1'b0;
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_bubble2: valid=%b expected 0", oDecOp.valid);
    end
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b1 || oDecOp.opClass !== OPIMM || oDecOp.imm !== 32'd5) begin
      errors++;
      $display("[TB] FAIL flush_resume: valid=%b class=%0d imm=%h expected 1/OPIMM/5",
               oDecOp.valid, oDecOp.opClass, oDecOp.imm);
    end
  endtask

  task automatic test_illegal_x0();
    @(negedge iClk);
    iInstr = 32'hFFFFFFFF;
    reg_op.dv = 1'b1; reg_op.addr = 5'd0; reg_op.data = 32'h1234;
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b1 || oDecOp.illegal !== 1'b1 || oDecOp.opClass !== ILLEGAL) begin
      errors++;
      $display("[TB] FAIL illegal_op: valid=%b illegal=%b class=%0d expected 1/1/ILLEGAL",
               oDecOp.valid, oDecOp.illegal, oDecOp.opClass);
    end
    @(negedge iClk);
    reg_op.dv = 1'b0;
    iInstr = 32'h00700093;
    @(posedge iClk); #1;
    checks++;
    if (oDecOp.valid !== 1'b1 || oDecOp.rs1Data !== 32'h0 || oDecOp.imm !== 32'd7) begin
      errors++;
      $display("[TB] FAIL x0_write_ignored: valid=%b rs1Data=%h imm=%h expected 1/0/7",
               oDecOp.valid, oDecOp.rs1Data, oDecOp.imm);
    end
  endtask

  task automatic test_random();
    tDecOp m_out, m_next;
    int    startup_left;
    bit    flush_tail, exp_lu;
    @(negedge iClk);
    iInstr = 32'h00A00113;
    reg_op.dv = 1'b1; reg_op.addr = 5'd1; reg_op.data = 32'hCAFEF00D;
    iRst = 1'b0;
    #1;
    checks++;
    if (oDecOp !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_op: decop=%h expected 0", oDecOp);
    end
    @(negedge iClk);
    iRst = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_out = '0;
    startup_left = 2;
    flush_tail = 0;
    for (int n = 0; n < 400; n++) begin
      iInstr = rand_instr();
      iCurPc = $urandom;
      iStall = ($urandom_range(0, 4) == 0);
      iFlush = ($urandom_range(0, 19) == 0);
      reg_op.dv   = ($urandom_range(0, 2) == 0);
      reg_op.addr = 5'($urandom_range(0, 3));
      reg_op.data = $urandom;
      #1;
      exp_lu = m_load_use(m_out, iInstr, reg_op);
      checks++;
      if (oLoadUse !== exp_lu) begin
        errors++;
        $display("[TB] FAIL rand_loaduse cycle %0d: got %b expected %b", n, oLoadUse, exp_lu);
      end
      if (startup_left > 0) begin
        m_next = '0;
        startup_left--;
      end else if (iFlush) begin
        m_next = '0;
        flush_tail = 1;
      end else if (flush_tail) begin
        m_next = '0;
        flush_tail = 0;
      end else if (iStall) begin
        m_next = m_out;
        if (reg_op.dv && reg_op.addr != 0 && reg_op.addr == m_out.rs1Addr) m_next.rs1Data = reg_op.data;
        if (reg_op.dv && reg_op.addr != 0 && reg_op.addr == m_out.rs2Addr) m_next.rs2Data = reg_op.data;
      end else if (exp_lu) begin
        m_next = '0;
      end else begin
        m_next = m_decode(iInstr);
        if (m_next.valid) m_next.pc = iCurPc;
        m_next.rs1Data = m_read(m_next.rs1Addr, reg_op);
        m_next.rs2Data = m_read(m_next.rs2Addr, reg_op);
      end
      if (reg_op.dv && reg_op.addr != 0) m_regs[reg_op.addr] = reg_op.data;
      @(posedge iClk); #1;
      checks++;
      if (oDecOp !== m_next) begin
        errors++;
        $display("[TB] FAIL rand_decop cycle %0d: got %h expected %h", n, oDecOp, m_next);
      end
      m_out = m_next;
      @(negedge iClk);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_bypass();
    test_stall_refresh();
    test_load_use();
    test_flush_stall();
    test_illegal_x0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter cStartupCycles, default 2, giving the number of bubble cycles after reset while the instruction RAM pipeline fills.
REQ-002 SHALL have port iClk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port iRst, input, 1 bit, the reset, asynchronous and active-low.
REQ-004 SHALL have port iInstr, input, cXLEN bits, the fetched instruction; value 0 means bubble.
REQ-005 SHALL have port iCurPc, input, cXLEN bits, the PC of iInstr.
REQ-006 SHALL have port iRegOp, input, tRegOp, the writeback request (dv, addr, data).
REQ-007 SHALL have port iStall, input, 1 bit, the downstream hold request.
REQ-008 SHALL have port iFlush, input, 1 bit, the branch/jump redirect kill.
REQ-009 SHALL have port oDecOp, output, tDecOp, the registered decoded op (valid, pc, opClass, funct3, funct7b5, rdAddr, rs1Addr, rs2Addr, rs1Data, rs2Data, imm, illegal).
REQ-010 SHALL have port oLoadUse, output, 1 bit, the combinational fetch-hold request.

Function
REQ-011 SHALL hold 31 registers x1..x31 of cXLEN bits; x0 SHALL read 0, and writes to x0 SHALL be ignored.
REQ-012 SHALL write iRegOp.data to register iRegOp.addr on the clock edge when iRegOp.dv=1.
REQ-013 SHALL decode opcode[6:0] into opClass LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP or ILLEGAL.
REQ-014 SHALL form the I, S, B, U and J immediates per opClass and sign-extend them to cXLEN.
REQ-015 SHALL register oDecOp with a latency of one cycle from iInstr/iCurPc.
REQ-016 SHALL run an FSM with states sInit, sRun and sFlush.
REQ-017 SHALL enter sInit on reset and output bubbles (valid=0) for cStartupCycles cycles before moving to sRun.
REQ-018 SHALL, when iFlush=1, emit a bubble on the next edge and go to sFlush; sFlush SHALL emit one further bubble and return to sRun.
REQ-019 SHALL give iFlush priority over iStall and oLoadUse.
REQ-020 SHALL, when iStall=1 and iFlush=0, hold oDecOp, but SHALL refresh held rs1Data/rs2Data if iRegOp writes a matching non-zero address.
REQ-021 SHALL treat iInstr=0 as a bubble (valid=0, illegal=0).
REQ-022 SHALL assert oLoadUse when oDecOp.valid=1, opClass=LOAD, rdAddr!=0, and the rs1/rs2 actually used by iInstr equals rdAddr.
REQ-023 SHALL, while oLoadUse=1, register a bubble; fetch re-presents the same instruction on the next cycle.
REQ-024 SHALL decode the writeback request, the stall and a new instruction arriving in the same cycle independently of one another.

Reset
REQ-025 SHALL, on iRst=0, clear all registers x1..x31, oDecOp (all fields 0) and the startup counter, and set the FSM to sInit.
REQ-026 SHALL, if reset is asserted mid-operation, abandon the in-flight op and drop any pending writeback.

Configuration
REQ-027 SHALL, when DECODE_RF_BYPASS_EN is defined, return iRegOp.data for an rs read whose address equals the same-cycle write (write-first).
REQ-028 SHALL, when DECODE_RF_BYPASS_EN is undefined, return the old register value on a same-cycle write, and oLoadUse SHALL additionally assert when iRegOp.dv=1 and iRegOp.addr matches a used rs (non-zero).

Structure
REQ-029 SHALL place tDecOp, the tOpClass enum, the opcode constants and cXLEN/cRegSelBitW in corePckg.
REQ-030 SHALL place the register file in sub-module reg_file (two async read ports, one write port).

Verification
REQ-031 SHALL verify reset then iInstr=0x00500093 on every cycle -> valid=0 for 2 cycles, then valid=1, OPIMM, rdAddr=1, imm=5.
REQ-032 SHALL verify iRegOp{dv=1, addr=3, data=0xDEADBEEF} with iInstr=0x00018133 in the same cycle, with DECODE_RF_BYPASS_EN defined -> rs1Data=0xDEADBEEF.
REQ-033 SHALL verify LOAD 0x0000A103 (rd=2) followed by 0x00210233 -> oLoadUse=1 for one cycle and one bubble, then the add issues.
REQ-034 SHALL verify iFlush=1 asserted together with iStall=1 -> two bubbles, then normal decode.
REQ-035 SHALL verify iInstr=0xFFFFFFFF -> valid=1, illegal=1; and a write to x0 of 0x1234 -> subsequent rs1Data=0.
